// File: rtl/cv32e40p_scnn_dmem_if.sv
// Data-memory bus between a requester (load/store unit or SCNN address
// unit) and cv32e40p_scnn_dmem.
//
// Signals:
//   data_req_i    requester -> memory  request
//   data_addr_i   requester -> memory  byte address (bits [1:0] ignored)
//   data_we_i     requester -> memory  1 = write, 0 = read
//   data_be_i     requester -> memory  byte enables, bit n = lane n
//   data_wdata_i  requester -> memory  write data
//   data_gnt_o    memory -> requester  request accepted this cycle
//   data_rvalid_o memory -> requester  one-cycle response pulse
//   data_rdata_o  memory -> requester  read data (valid with rvalid)
//   data_err_o    memory -> requester  access error (valid with rvalid)
interface cv32e40p_scnn_dmem_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/cv32e40p_scnn_dmem.sv
// Word-organised data memory with a req/gnt/rvalid handshake and a
// programmable response delay.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   bus        slave side of cv32e40p_scnn_dmem_if
//   acc_cnt_o  number of granted requests (wraps)
//
// Parameters:
//   BASE_ADDR    byte address of word 0
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between grant and response (0..7)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no response pending, grants accepted
// WAIT  | access done, counting down before the response, no grants
// RESP  | rvalid asserted this cycle, grants accepted
module cv32e40p_scnn_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  cv32e40p_scnn_dmem_if.slave     bus,
  output logic [31:0]             acc_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One past the last valid byte, kept 33 bits wide so the top of the
  // address space cannot wrap into the valid window.
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] acc_cnt_q;

  logic [31:0] mem [DEPTH];

  assign offset   = bus.data_addr_i - BASE_ADDR;
  assign idx      = AW'(offset >> 2);
  assign in_range = ({1'b0, bus.data_addr_i} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, bus.data_addr_i} <  LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        gnt = bus.data_req_i;
        if (bus.data_req_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    // Grant must read low for the whole reset, not only after the
    // first edge.
    if (rst) begin
      gnt = 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (gnt && bus.data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_be_i[i]) begin
          mem[idx][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Response data is captured on the grant edge so the request fields
  // need not be held during the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      acc_cnt_q <= 32'h0;
    end else if (gnt) begin
      rdata_q   <= (!bus.data_we_i && in_range) ? mem[idx] : 32'h0;
      err_q     <= !in_range;
      acc_cnt_q <= acc_cnt_q + 32'd1;
    end
  end

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = (state_q == RESP);
  assign bus.data_rdata_o  = (state_q == RESP) ? rdata_q : 32'h0;
  assign bus.data_err_o    = (state_q == RESP) && err_q;
  assign acc_cnt_o         = acc_cnt_q;

endmodule

// File: tb/tb_cv32e40p_scnn_dmem.sv
// Bench for cv32e40p_scnn_dmem: three instances with WAIT_CYCLES 0, 2, 3.
module tb_cv32e40p_scnn_dmem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cv32e40p_scnn_dmem_if bus0 ();
  cv32e40p_scnn_dmem_if bus2 ();
  cv32e40p_scnn_dmem_if bus3 ();
  logic [31:0] acc0, acc2, acc3;

  cv32e40p_scnn_dmem #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .acc_cnt_o(acc0));
  cv32e40p_scnn_dmem #(.BASE_ADDR(32'h0), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .acc_cnt_o(acc2));
  cv32e40p_scnn_dmem #(.BASE_ADDR(32'h100), .DEPTH(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .acc_cnt_o(acc3));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt0[18];
  vec_t vt3[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
    bus0.data_we_i = we; bus0.data_addr_i = addr; bus0.data_be_i = be; bus0.data_wdata_i = wdata;
    bus2.data_we_i = we; bus2.data_addr_i = addr; bus2.data_be_i = be; bus2.data_wdata_i = wdata;
    bus3.data_we_i = we; bus3.data_addr_i = addr; bus3.data_be_i = be; bus3.data_wdata_i = wdata;
  endtask

  // Write-shaped junk on the bus while no request is up; it must not land.
  task automatic garbage();
    logic [31:0] r;
    r = $urandom;
    set_fields(1'b1, 32'h10, 4'hF, r);
    bus3.data_addr_i = 32'h108;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus0.data_req_i = 1'b0; bus2.data_req_i = 1'b0; bus3.data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic txn0(input vec_t v, input int n);
    @(negedge clk);
    chk($sformatf("d0 v%0d idle rvalid", n), 32'(bus0.data_rvalid_o), 32'd0);
    chk($sformatf("d0 v%0d idle rdata", n), bus0.data_rdata_o, 32'd0);
    set_fields(v.we, v.addr, v.be, v.wdata);
    bus0.data_req_i = 1'b1;
    #1;
    chk($sformatf("d0 v%0d gnt", n), 32'(bus0.data_gnt_o), 32'd1);
    @(negedge clk);
    bus0.data_req_i = 1'b0;
    garbage();
    #1;
    chk($sformatf("d0 v%0d rvalid", n), 32'(bus0.data_rvalid_o), 32'd1);
    chk($sformatf("d0 v%0d rdata", n), bus0.data_rdata_o, v.rdata);
    chk($sformatf("d0 v%0d err", n), 32'(bus0.data_err_o), 32'(v.err));
  endtask

  task automatic txn3(input vec_t v, input int n);
    @(negedge clk);
    chk($sformatf("d3 v%0d idle rvalid", n), 32'(bus3.data_rvalid_o), 32'd0);
    set_fields(v.we, v.addr, v.be, v.wdata);
    bus3.data_req_i = 1'b1;
    #1;
    chk($sformatf("d3 v%0d gnt", n), 32'(bus3.data_gnt_o), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus3.data_req_i = 1'b0;
        garbage();
      end
      #1;
      if (c < 4) begin
        chk($sformatf("d3 v%0d rvalid early c%0d", n, c), 32'(bus3.data_rvalid_o), 32'd0);
      end else begin
        chk($sformatf("d3 v%0d rvalid", n), 32'(bus3.data_rvalid_o), 32'd1);
        chk($sformatf("d3 v%0d rdata", n), bus3.data_rdata_o, v.rdata);
        chk($sformatf("d3 v%0d err", n), 32'(bus3.data_err_o), 32'(v.err));
      end
    end
  endtask

  initial begin
    vt0[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vt0[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt0[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
    vt0[3]  = '{1'b1, 32'h0000_0020, 4'h4, 32'hAABB_CCDD, 32'h0,         1'b0};
    vt0[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h11BB_3344, 1'b0};
    vt0[5]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0};
    vt0[6]  = '{1'b1, 32'h0000_0024, 4'h0, 32'h1234_5678, 32'h0,         1'b0};
    vt0[7]  = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vt0[8]  = '{1'b1, 32'h0000_0028, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vt0[9]  = '{1'b1, 32'h0000_0028, 4'h3, 32'h0000_ABCD, 32'h0,         1'b0};
    vt0[10] = '{1'b0, 32'h0000_002B, 4'h0, 32'h0,         32'hFFFF_ABCD, 1'b0};
    vt0[11] = '{1'b1, 32'h0000_0000, 4'hF, 32'h1357_9BDF, 32'h0,         1'b0};
    vt0[12] = '{1'b0, 32'h0000_0400, 4'hF, 32'h0,         32'h0,         1'b1};
    vt0[13] = '{1'b1, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vt0[14] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h1357_9BDF, 1'b0};
    vt0[15] = '{1'b1, 32'h0000_03FC, 4'hF, 32'h0BAD_CAFE, 32'h0,         1'b0};
    vt0[16] = '{1'b0, 32'h0000_03FC, 4'hF, 32'h0,         32'h0BAD_CAFE, 1'b0};
    vt0[17] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'h0,         1'b1};

    vt3[0]  = '{1'b1, 32'h0000_0108, 4'hF, 32'hAABB_0011, 32'h0,         1'b0};
    vt3[1]  = '{1'b0, 32'h0000_0108, 4'hF, 32'h0,         32'hAABB_0011, 1'b0};
    vt3[2]  = '{1'b0, 32'h0000_00FC, 4'hF, 32'h0,         32'h0,         1'b1};
    vt3[3]  = '{1'b0, 32'h0000_0140, 4'hF, 32'h0,         32'h0,         1'b1};
    vt3[4]  = '{1'b1, 32'h0000_013C, 4'hF, 32'h0102_0304, 32'h0,         1'b0};

    // Reset state, with a request already up.
    bus0.data_req_i = 1'b1; bus2.data_req_i = 1'b0; bus3.data_req_i = 1'b0;
    set_fields(1'b0, 32'h0, 4'hF, 32'h0);
    #12;
    chk("rst gnt", 32'(bus0.data_gnt_o), 32'd0);
    chk("rst rvalid", 32'(bus0.data_rvalid_o), 32'd0);
    chk("rst rdata", bus0.data_rdata_o, 32'd0);
    chk("rst err", 32'(bus0.data_err_o), 32'd0);
    chk("rst acc", acc0, 32'd0);
    bus0.data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) txn0(vt0[i], i);
    chk("d0 table acc", acc0, 32'd18);

    // Write then read the same word on consecutive grants.
    txn0('{1'b1, 32'h50, 4'hF, 32'h0, 32'h0, 1'b0}, 99);
    do_reset();
    set_fields(1'b1, 32'h50, 4'hF, 32'hDEAD_BEEF);
    bus0.data_req_i = 1'b1;
    @(negedge clk);
    set_fields(1'b0, 32'h50, 4'hF, 32'h0);
    #1;
    chk("b2b wr rvalid", 32'(bus0.data_rvalid_o), 32'd1);
    chk("b2b wr rdata", bus0.data_rdata_o, 32'd0);
    chk("b2b rd gnt", 32'(bus0.data_gnt_o), 32'd1);
    @(negedge clk);
    bus0.data_req_i = 1'b0;
    #1;
    chk("b2b rd rvalid", 32'(bus0.data_rvalid_o), 32'd1);
    chk("b2b rd rdata", bus0.data_rdata_o, 32'hDEAD_BEEF);
    chk("b2b rd err", 32'(bus0.data_err_o), 32'd0);
    chk("b2b acc", acc0, 32'd2);

    // Streaming: 16 writes, reset, 16 reads back to back.
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin
        set_fields(1'b1, 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
        bus0.data_req_i = 1'b1;
      end else begin
        bus0.data_req_i = 1'b0;
      end
    end
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("stream rvalid %0d", i - 1), 32'(bus0.data_rvalid_o), 32'd1);
        chk($sformatf("stream rdata %0d", i - 1), bus0.data_rdata_o, 32'hA000_0000 + 32'(i - 1));
      end
      if (i < 16) begin
        set_fields(1'b0, 32'(4 * i), 4'hF, 32'h0);
        bus0.data_req_i = 1'b1;
        #1;
        chk($sformatf("stream gnt %0d", i), 32'(bus0.data_gnt_o), 32'd1);
      end else begin
        bus0.data_req_i = 1'b0;
      end
    end
    chk("stream acc", acc0, 32'd16);
    @(negedge clk);
    chk("stream end rvalid", 32'(bus0.data_rvalid_o), 32'd0);

    // WAIT_CYCLES=3 with non-zero base.
    do_reset();
    for (int i = 0; i < 5; i++) txn3(vt3[i], i);
    txn3('{1'b0, 32'h13C, 4'h0, 32'h0, 32'h0102_0304, 1'b0}, 5);
    chk("d3 acc", acc3, 32'd6);

    // Request held across the wait.
    do_reset();
    @(negedge clk);
    set_fields(1'b1, 32'h110, 4'hF, 32'h5A5A_5A5A);
    bus3.data_req_i = 1'b1;
    #1;
    chk("hold gnt c0", 32'(bus3.data_gnt_o), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold gnt c%0d", c), 32'(bus3.data_gnt_o), 32'd0);
      chk($sformatf("hold rvalid c%0d", c), 32'(bus3.data_rvalid_o), 32'd0);
    end
    @(negedge clk);
    chk("hold rvalid c4", 32'(bus3.data_rvalid_o), 32'd1);
    chk("hold gnt c4", 32'(bus3.data_gnt_o), 32'd1);
    chk("hold rdata c4", bus3.data_rdata_o, 32'd0);
    bus3.data_req_i = 1'b0;
    chk("hold acc", acc3, 32'd1);

    // WAIT_CYCLES=2: reset hits during the wait.
    do_reset();
    @(negedge clk);
    set_fields(1'b1, 32'h60, 4'hF, 32'h7777_7777);
    bus2.data_req_i = 1'b1;
    #1;
    chk("wrst gnt", 32'(bus2.data_gnt_o), 32'd1);
    @(negedge clk);
    chk("wrst wait rvalid", 32'(bus2.data_rvalid_o), 32'd0);
    chk("wrst wait acc", acc2, 32'd1);
    rst = 1'b1;
    #1;
    chk("wrst in rst gnt", 32'(bus2.data_gnt_o), 32'd0);
    chk("wrst in rst rvalid", 32'(bus2.data_rvalid_o), 32'd0);
    chk("wrst in rst rdata", bus2.data_rdata_o, 32'd0);
    chk("wrst in rst err", 32'(bus2.data_err_o), 32'd0);
    chk("wrst in rst acc", acc2, 32'd0);
    @(negedge clk);
    bus2.data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("wrst post rvalid %0d", c), 32'(bus2.data_rvalid_o), 32'd0);
    end
    chk("wrst post acc", acc2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
